// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the instruction fetch slice.
//   XLEN          - architectural register / address width
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0), shown when no instruction is valid
//   *_LSB / *_W   - instruction field positions used to feed the controller
//   fetch_entry_t - one prefetched instruction word together with its PC
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB     = 0;
    localparam int OP_W       = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_W   = 3;
    localparam int FUNCT7B5   = 30;

    typedef struct packed {
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, reset_n - clock, asynchronous active-low reset (clears pointers/count)
//   push, push_entry - write one entry (caller guarantees no overflow)
//   pop          - drop the head entry (caller guarantees not empty)
//   flush        - empty the FIFO; wins over push and pop in the same cycle
//   count        - number of valid entries (0..DEPTH)
//   head         - oldest entry; contents undefined while count == 0
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage holds data only; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the single-cycle controller.
// Owns the PC, issues in-order pipelined requests to a variable-latency
// instruction memory, buffers returned words in a prefetch FIFO and presents
// the head instruction (with PC and PC+4) to decode. redirect (PCSrc) flushes
// the stream and restarts fetch at redirect_target.
//   clk, reset_n                   - clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr - fetch request channel
//   imem_rsp_valid, imem_rsp_data  - in-order response words
//   redirect, redirect_target      - PCSrc / PCTarget, qualified by instr_valid
//   instr_valid/ready, instr       - head instruction to decode
//   instr_pc, instr_pcplus4        - PC of head and PC+4
//   op, funct3, funct7b5           - controller decode fields of instr
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on the same-cycle ready, and the payload is
// stable while valid is high. The response channel has no ready: every
// response is taken in the cycle it is presented.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   inflight_next;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            req_fire;
    logic            redirect_fire;
    logic            push;
    logic            pop;
    logic            target_unused;

    // Every request either sits in memory or owns a FIFO slot, so the FIFO
    // can never overflow. Only registered state feeds this, keeping
    // imem_req_valid free of any path from decode. Held low during reset.
    assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid = reset_n && (credit_used < (CW + 1)'(DEPTH));
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign redirect_fire  = redirect && instr_valid;
    assign inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

    // Responses owed to a flushed stream are swallowed while drop is nonzero.
    assign push            = imem_rsp_valid && (drop == '0);
    assign pop             = instr_valid && instr_ready && !redirect_fire;
    assign push_entry.word = imem_rsp_data;
    // Responses return in order, so the PC of the oldest live request is
    // the issue PC minus everything still ahead of it in memory.
    assign push_entry.pc   = fetch_pc - {{(XLEN - CW - 2){1'b0}}, inflight, 2'b00};

    assign target_unused  = ^redirect_target[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_fire) begin
                fetch_pc <= {redirect_target[31:2], 2'b00};
                // Everything still outstanding after this edge, including a
                // request accepted right now, belongs to the old stream.
                drop     <= inflight_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_fire),
        .count      (fifo_count),
        .head       (head)
    );

    assign instr_valid   = (fifo_count != '0);
    assign instr         = instr_valid ? head.word : NOP_INSTR;
    assign instr_pc      = instr_valid ? head.pc : '0;
    assign instr_pcplus4 = instr_pc + 32'd4;
    assign op            = instr[OP_LSB +: OP_W];
    assign funct3        = instr[FUNCT3_LSB +: FUNCT3_W];
    assign funct7b5      = instr[FUNCT7B5];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;

    int n_checks = 0;
    int n_errors = 0;

    // memory model state
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    int          cyc     = 0;
    int          lat     = 1;
    int          max_out = 0;

    logic [31:0] nxt;
    int          n;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pcplus4   (instr_pcplus4),
        .op              (op),
        .funct3          (funct3),
        .funct7b5        (funct7b5)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address-derived instruction words with varying op/funct fields.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h4000_5000 ^ {a[7:0], 24'h0};
    endfunction

    // Memory: accepts every request, answers in order after lat cycles.
    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (imem_rsp_valid && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + lat - 1);
            end
            if (pend_addr.size() > max_out) max_out = pend_addr.size();
        end
        #1;
        if (reset_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // scoreboard helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a valid head and check it is the instruction at pc;
    // instr_ready is high, so it is consumed at the following edge.
    task automatic expect_next(input logic [31:0] pc);
        int k;
        logic [31:0] w;
        k = 0;
        while (!instr_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        w = word_of(pc);
        chk($sformatf("valid@%h", pc), {31'b0, instr_valid}, 32'd1);
        chk($sformatf("pc@%h", pc), instr_pc, pc);
        chk($sformatf("pc4@%h", pc), instr_pcplus4, pc + 32'd4);
        chk($sformatf("instr@%h", pc), instr, w);
        chk($sformatf("op@%h", pc), {25'b0, op}, {25'b0, w[6:0]});
        chk($sformatf("f3@%h", pc), {29'b0, funct3}, {29'b0, w[14:12]});
        chk($sformatf("f7b5@%h", pc), {31'b0, funct7b5}, {31'b0, w[30]});
        @(negedge clk);
    endtask

    // One-cycle redirect followed by the zero-wait penalty timing checks.
    task automatic redirect_zero_wait(input string tag, input logic [31:0] tgt);
        redirect        = 1'b1;
        redirect_target = tgt;
        @(negedge clk);
        redirect        = 1'b0;
        redirect_target = 32'h0;
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd1);
        chk({tag, "_req_addr"}, imem_addr, {tgt[31:2], 2'b00});
        @(negedge clk);
        chk({tag, "_gap"}, {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_tgt_valid"}, {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_pc"}, instr_pc, 32'h0);
        chk({tag, "_pc4"}, instr_pcplus4, 32'h4);
        chk({tag, "_op"}, {25'b0, op}, 32'h13);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        imem_req_ready  = 1'b1;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        instr_ready     = 1'b1;
        lat             = 1;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // release: first request at RESET_PC in cycle 0
        reset_n = 1'b1;
        #1;
        chk("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("c1_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("c1_addr", imem_addr, 32'h4);
        @(negedge clk);
        chk("c2_instr_valid", {31'b0, instr_valid}, 32'd1);
        expect_next(32'h0);
        expect_next(32'h4);
        expect_next(32'h8);
        expect_next(32'hC);
        nxt = 32'h10;

        // three-cycle memory latency
        lat = 3;
        for (int i = 0; i < 6; i++) begin
            expect_next(nxt);
            nxt = nxt + 32'd4;
        end

        // decode stalled: FIFO fills and requests stop
        lat = 1;
        instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("stall_head_pc", instr_pc, nxt);
        chk("stall_fetch_pc", imem_addr, nxt + 32'd8);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_next(nxt);
            nxt = nxt + 32'd4;
        end

        // redirect with slow memory and old requests outstanding
        lat = 3;
        expect_next(nxt);
        nxt = nxt + 32'd4;
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd3_head_pc", instr_pc, nxt);
        redirect        = 1'b1;
        redirect_target = 32'h0000_0103;
        @(negedge clk);
        redirect        = 1'b0;
        redirect_target = 32'h0;
        expect_next(32'h100);
        expect_next(32'h104);

        // redirect in the same cycle as a request handshake
        lat = 1;
        expect_next(32'h108);
        n = 0;
        while (!(instr_valid && imem_req_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("find_req_cycle", {31'b0, instr_valid && imem_req_valid}, 32'd1);
        redirect_zero_wait("rdreq", 32'h0000_0200);
        expect_next(32'h200);
        expect_next(32'h204);

        // redirect in the same cycle as a response
        n = 0;
        while (!(instr_valid && imem_rsp_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("find_rsp_cycle", {31'b0, instr_valid && imem_rsp_valid}, 32'd1);
        redirect_zero_wait("rdrsp", 32'h0000_0302);
        expect_next(32'h300);
        expect_next(32'h304);

        // PC wrap at the top of the address space
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        redirect_zero_wait("wrap", 32'hFFFF_FFFC);
        chk("wrap_pc4", instr_pcplus4, 32'h0);
        expect_next(32'hFFFF_FFFC);
        expect_next(32'h0);
        expect_next(32'h4);

        // asynchronous reset pulse mid-stream
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("restart_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        expect_next(32'h0);
        expect_next(32'h4);

        chk("max_outstanding_le_depth", {31'b0, (max_out <= 2)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
